// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request-decode helpers for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   lane_be = 4'b0001 << lane;
      2'b01:   lane_be = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Illegal width code takes precedence over misalignment.
  function automatic logic [1:0] check_req(input logic is_store, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic illegal;
    illegal = is_store ? (f3 >= 3'b011)
                       : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    if (illegal)                                check_req = ERR_ILLEGAL;
    else if (f3[1:0] == 2'b01 && lane[0])       check_req = ERR_MISALIGN;
    else if (f3[1:0] == 2'b10 && lane != 2'b00) check_req = ERR_MISALIGN;
    else                                        check_req = ERR_NONE;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a memory word and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    case (lane)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
    sel_half = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      LB:      data = {{24{sel_byte[7]}}, sel_byte};
      LBU:     data = {24'd0, sel_byte};
      LH:      data = {{16{sel_half[15]}}, sel_half};
      LHU:     data = {16'd0, sel_half};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: one request per transaction, req/ack handshake with timeout.
//   state   | meaning
//   ST_IDLE | waiting for start; memory outputs held at 0
//   ST_REQ  | mem_req high, waiting for mem_ack or timeout
//   ST_DONE | one-cycle done pulse with rdata/err valid
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state, state_nxt;
  logic [15:0] cnt;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [1:0]  req_err;
  logic [31:0] load_data;

  lsu_load_align u_align (
    .funct3 (f3_q),
    .lane   (lane_q),
    .word   (mem_rdata),
    .data   (load_data)
  );

  assign mem_req = (state == ST_REQ);
  assign done    = (state == ST_DONE);
  assign busy    = (state != ST_IDLE);

  always_comb begin
    req_err   = check_req(is_store, funct3, addr[1:0]);
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (req_err == ERR_NONE) ? ST_REQ : ST_DONE;
      ST_REQ:  if (mem_ack || cnt == TO_LAST) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      f3_q      <= '0;
      lane_q    <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          if (req_err == ERR_NONE) begin
            cnt      <= '0;
            f3_q     <= funct3;
            lane_q   <= addr[1:0];
            mem_we   <= is_store;
            mem_addr <= {addr[ADDR_W-1:2], 2'b00};
            mem_be   <= lane_be(funct3, addr[1:0]);
            if (!is_store)                mem_wdata <= '0;
            else if (funct3[1:0] == 2'b00) mem_wdata <= {4{wdata[7:0]}};
            else if (funct3[1:0] == 2'b01) mem_wdata <= {2{wdata[15:0]}};
            else                           mem_wdata <= wdata;
          end else begin
            err      <= 1'b1;
            err_code <= req_err;
            rdata    <= '0;
          end
        end
        ST_REQ: begin
          if (mem_ack || cnt == TO_LAST) begin
            // ack on the final counted cycle still wins over the timeout
            rdata     <= (mem_ack && !mem_we) ? load_data : 32'd0;
            err       <= !mem_ack;
            err_code  <= mem_ack ? ERR_NONE : ERR_TIMEOUT;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          err      <= 1'b0;
          err_code <= ERR_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a behavioural access model.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        done, busy, err;
  logic [1:0]  err_code;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] hold_rdata = '0;

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .busy      (busy),
    .err       (err),
    .err_code  (err_code),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ack_dly: REQ cycle index at which mem_ack is given; outside 0..TO-1 means never
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int ack_dly);
    int          lane, nbytes;
    logic [1:0]  exp_code;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd, sh;
    logic [7:0]  b;
    logic [15:0] h;
    bit          acked;
    lane   = int'(a[1:0]);
    nbytes = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    if (st ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) exp_code = 2'b10;
    else if (lane % nbytes != 0)                                        exp_code = 2'b01;
    else                                                                exp_code = 2'b00;
    exp_be = 4'(((1 << nbytes) - 1) << lane);
    if (!st)              exp_wd = 32'd0;
    else if (nbytes == 1) exp_wd = wd[7:0] * 32'h01010101;
    else if (nbytes == 2) exp_wd = wd[15:0] * 32'h00010001;
    else                  exp_wd = wd;
    sh = rd >> (8 * lane);
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'd0:    exp_rd = {{24{b[7]}}, b};
      3'd4:    exp_rd = {24'd0, b};
      3'd1:    exp_rd = {{16{h[15]}}, h};
      3'd5:    exp_rd = {16'd0, h};
      default: exp_rd = rd;
    endcase

    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    start = 1'b0; wdata = $urandom; addr = $urandom;
    acked = 1'b0;
    if (exp_code == 2'b00) begin
      for (int c = 0; c < TO; c++) begin
        check_val("mem_req", 32'(mem_req), 32'd1);
        check_val("mem_addr", mem_addr, {a[31:2], 2'b00});
        check_val("mem_be", 32'(mem_be), 32'(exp_be));
        check_val("mem_we", 32'(mem_we), 32'(st));
        check_val("mem_wdata", mem_wdata, exp_wd);
        if (c == ack_dly) begin mem_ack = 1'b1; mem_rdata = rd; end
        else mem_rdata = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        if (c == ack_dly) begin acked = 1'b1; break; end
      end
      if (!acked) exp_code = 2'b11;
    end
    hold_rdata = (acked && !st) ? exp_rd : 32'd0;
    check_val("done", 32'(done), 32'd1);
    check_val("err", 32'(err), 32'(exp_code != 2'b00));
    check_val("err_code", 32'(err_code), 32'(exp_code));
    check_val("rdata", rdata, hold_rdata);
    check_val("req_in_done", 32'(mem_req), 32'd0);
    @(negedge clk);
    check_val("done_clr", 32'(done), 32'd0);
    check_val("busy_clr", 32'(busy), 32'd0);
    check_val("idle_be", 32'(mem_be), 32'd0);
    check_val("rdata_hold", rdata, hold_rdata);
  endtask

  initial begin
    int dones;
    #1;
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_req", 32'(mem_req), 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_addr", mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_txn(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 3);
    run_txn(1'b1, 3'd0, 32'h203, 32'h000000A5, 32'h0, 1);
    run_txn(1'b0, 3'd0, 32'h102, 32'h0, 32'h1280FF34, 0);
    check_val("lb_value", rdata, 32'hFFFFFF80);
    run_txn(1'b0, 3'd4, 32'h102, 32'h0, 32'h1280FF34, 2);
    check_val("lbu_value", rdata, 32'h00000080);
    run_txn(1'b0, 3'd5, 32'h102, 32'h0, 32'h1280FF34, 1);
    check_val("lhu_value", rdata, 32'h00001280);
    run_txn(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0);
    run_txn(1'b1, 3'd4, 32'h100, 32'h1234, 32'h0, 0);
    run_txn(1'b0, 3'd2, 32'h100, 32'h0, 32'hCAFEF00D, -1);
    run_txn(1'b0, 3'd2, 32'h104, 32'h0, 32'hCAFEF00D, 0);
    run_txn(1'b0, 3'd1, 32'h106, 32'h0, 32'h8001ABCD, TO - 1);

    // mem_ack outside REQ must not start anything
    @(negedge clk); mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0;
    check_val("stray_ack_busy", 32'(busy), 32'd0);
    check_val("stray_ack_done", 32'(done), 32'd0);

    // reset during REQ aborts with no done
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h40;
    @(negedge clk); start = 1'b0;
    check_val("pre_rst_req", 32'(mem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_val("mid_rst_req", 32'(mem_req), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    hold_rdata = 32'd0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); dones += int'(done); end
    check_val("rst_no_done", 32'(dones), 32'd0);

    // second start while busy is dropped
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h80;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dones += int'(done);
      start = (i == 0);
      mem_ack = (i == 1);
      mem_rdata = (i == 1) ? 32'h5A5A1234 : 32'h0;
    end
    check_val("busy_one_done", 32'(dones), 32'd1);
    check_val("busy_rdata", rdata, 32'h5A5A1234);

    for (int k = 0; k < 40; k++) begin
      int d;
      d = int'($urandom_range(0, 5));
      run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
